// File: rtl/cg_rate_accumulator.sv
// Per-coefficient-group rate accumulator for RDOQ: sums context-coded and bypass sign-bin costs
// over one CG, applies the sign-data-hiding discount and emits the result on valid/ready.
module cg_rate_accumulator #(
   parameter logic [15:0] IEP_RATE = 16'h8000,
   parameter bit          SBH_EN   = 1'b1,
   parameter int unsigned CG_SIZE  = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        coeff_valid,
   output logic        coeff_ready,
   input  logic [15:0] coeff_abs,
   input  logic        coeff_last,
   input  logic [31:0] ctx_rate,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] cg_rate,
   output logic [4:0]  nz_count,
   output logic        sign_hidden
);

   localparam logic [4:0] LastIdx = 5'(CG_SIZE - 1);

   typedef enum logic [1:0] {StIdle, StAccum, StFinal, StOutput} state_e;

   state_e      state_q;
   logic [31:0] acc_q;
   logic [4:0]  nz_q;
   logic [4:0]  idx_q;
   logic [3:0]  first_nz_q;
   logic [3:0]  last_nz_q;

   logic        handshake;
   logic        nonzero;
   logic        group_close;
   logic        hide;
   logic [32:0] coeff_cost;
   logic [33:0] acc_base;
   logic [33:0] acc_sum;
   logic [31:0] acc_sat;
   logic [4:0]  nz_span;

   always_comb begin
      coeff_ready = (state_q == StIdle) || (state_q == StAccum);
      handshake   = coeff_valid & coeff_ready;
      nonzero     = coeff_abs != 16'd0;
      group_close = coeff_last || (idx_q == LastIdx);
      coeff_cost  = {1'b0, ctx_rate} + (nonzero ? {17'd0, IEP_RATE} : 33'd0);
      // IDLE loads rather than adds, so the first coefficient never sees a stale sum.
      acc_base    = (state_q == StIdle) ? 34'd0 : {2'b00, acc_q};
      acc_sum     = acc_base + {1'b0, coeff_cost};
      acc_sat     = (acc_sum[33:32] != 2'b00) ? 32'hFFFF_FFFF : acc_sum[31:0];
      nz_span     = {1'b0, last_nz_q} - {1'b0, first_nz_q};
      hide        = SBH_EN && (nz_q != 5'd0) && (nz_span >= 5'd4);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         acc_q       <= '0;
         nz_q        <= '0;
         idx_q       <= '0;
         first_nz_q  <= '0;
         last_nz_q   <= '0;
         out_valid   <= 1'b0;
         cg_rate     <= '0;
         nz_count    <= '0;
         sign_hidden <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle, StAccum: begin
               if (handshake) begin
                  acc_q <= acc_sat;
                  idx_q <= idx_q + 5'd1;
                  if (nonzero) begin
                     if (nz_q == 5'd0) first_nz_q <= idx_q[3:0];
                     last_nz_q <= idx_q[3:0];
                     nz_q      <= nz_q + 5'd1;
                  end
                  state_q <= group_close ? StFinal : StAccum;
               end
            end
            StFinal: begin
               // hide implies a nonzero coefficient, so acc_q >= IEP_RATE here.
               sign_hidden <= hide;
               cg_rate     <= hide ? (acc_q - {16'd0, IEP_RATE}) : acc_q;
               nz_count    <= nz_q;
               out_valid   <= 1'b1;
               state_q     <= StOutput;
            end
            StOutput: begin
               if (out_ready) begin
                  out_valid  <= 1'b0;
                  acc_q      <= '0;
                  nz_q       <= '0;
                  idx_q      <= '0;
                  first_nz_q <= '0;
                  last_nz_q  <= '0;
                  state_q    <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_cg_rate_accumulator.sv
// Randomized self-checking bench for cg_rate_accumulator; drives a hiding and a non-hiding
// instance with identical stimulus and compares both against a list-based rate model.
module tb_cg_rate_accumulator;

   logic        clk;
   logic        rst;
   logic        coeff_valid;
   logic [15:0] coeff_abs;
   logic        coeff_last;
   logic [31:0] ctx_rate;
   logic        out_ready;

   logic        ready_a, valid_a, hid_a;
   logic [31:0] rate_a;
   logic [4:0]  nz_a;
   logic        ready_b, valid_b, hid_b;
   logic [31:0] rate_b;
   logic [4:0]  nz_b;

   int tests_run    = 0;
   int tests_failed = 0;

   int grp_len;
   int grp_abs[16];
   int unsigned grp_ctx[16];

   cg_rate_accumulator #(.IEP_RATE(16'h8000), .SBH_EN(1'b1), .CG_SIZE(16)) dut_sdh (
      .clk(clk), .rst(rst), .coeff_valid(coeff_valid), .coeff_ready(ready_a),
      .coeff_abs(coeff_abs), .coeff_last(coeff_last), .ctx_rate(ctx_rate),
      .out_valid(valid_a), .out_ready(out_ready), .cg_rate(rate_a), .nz_count(nz_a),
      .sign_hidden(hid_a)
   );

   cg_rate_accumulator #(.IEP_RATE(16'h8000), .SBH_EN(1'b0), .CG_SIZE(16)) dut_nosdh (
      .clk(clk), .rst(rst), .coeff_valid(coeff_valid), .coeff_ready(ready_b),
      .coeff_abs(coeff_abs), .coeff_last(coeff_last), .ctx_rate(ctx_rate),
      .out_valid(valid_b), .out_ready(out_ready), .cg_rate(rate_b), .nz_count(nz_b),
      .sign_hidden(hid_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: plain sum of all bin costs, clipped once, then the hiding rule on scan positions.
   task automatic model(input bit sdh, output logic [31:0] rate, output logic [4:0] nz,
                        output logic hid);
      longint total = 0;
      int first = -1, last = -1, cnt = 0;
      for (int i = 0; i < grp_len; i++) begin
         total += grp_ctx[i];
         if (grp_abs[i] != 0) begin
            total += 32768;
            cnt++;
            if (first < 0) first = i;
            last = i;
         end
      end
      if (total > 64'hFFFF_FFFF) total = 64'hFFFF_FFFF;
      hid  = sdh && cnt > 0 && (last - first) >= 4;
      rate = hid ? 32'(total - 32768) : 32'(total);
      nz   = 5'(cnt);
   endtask

   // Sends the stored group, then checks latency, result and (optionally) output backpressure.
   task automatic run_group(input string tag, input bit use_last, input int bp_cycles);
      logic [31:0] er_a, er_b;
      logic [4:0]  en_a, en_b;
      logic        eh_a, eh_b;
      model(1'b1, er_a, en_a, eh_a);
      model(1'b0, er_b, en_b, eh_b);
      out_ready = (bp_cycles == 0);
      for (int i = 0; i < grp_len; i++) begin
         if (i != 0 && $urandom_range(0, 5) == 0) begin
            coeff_valid = 1'b0;
            @(posedge clk); #1;
         end
         coeff_valid = 1'b1;
         coeff_abs   = 16'(grp_abs[i]);
         ctx_rate    = grp_ctx[i];
         coeff_last  = use_last && (i == grp_len - 1);
         @(posedge clk); #1;
      end
      coeff_valid = 1'b0;
      coeff_last  = 1'b0;
      check({tag, " final_valid"}, {31'd0, valid_a}, 32'd0);
      check({tag, " final_ready"}, {31'd0, ready_a}, 32'd0);
      @(posedge clk); #1;
      check({tag, " out_valid"}, {31'd0, valid_a}, 32'd1);
      check({tag, " rate_sdh"}, rate_a, er_a);
      check({tag, " nz_sdh"}, {27'd0, nz_a}, {27'd0, en_a});
      check({tag, " hid_sdh"}, {31'd0, hid_a}, {31'd0, eh_a});
      check({tag, " rate_nosdh"}, rate_b, er_b);
      check({tag, " hid_nosdh"}, {31'd0, hid_b}, {31'd0, eh_b});
      for (int c = 0; c < bp_cycles; c++) begin
         coeff_valid = 1'b1;
         coeff_abs   = 16'd7;
         ctx_rate    = 32'd12345;
         @(posedge clk); #1;
         check({tag, " bp_valid"}, {31'd0, valid_a}, 32'd1);
         check({tag, " bp_rate"}, rate_a, er_a);
         check({tag, " bp_ready"}, {31'd0, ready_a}, 32'd0);
      end
      coeff_valid = 1'b0;
      out_ready   = 1'b1;
      @(posedge clk); #1;
      check({tag, " valid_drop"}, {31'd0, valid_a}, 32'd0);
      check({tag, " rate_held"}, rate_a, er_a);
      check({tag, " idle_ready"}, {31'd0, ready_a}, 32'd1);
   endtask

   task automatic fill(input int len, input int abs_v, input int unsigned ctx_v);
      grp_len = len;
      for (int i = 0; i < 16; i++) begin
         grp_abs[i] = abs_v;
         grp_ctx[i] = ctx_v;
      end
   endtask

   initial begin
      rst = 1'b1;
      coeff_valid = 1'b1;
      coeff_abs = 16'd5;
      coeff_last = 1'b0;
      ctx_rate = 32'd99;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst out_valid", {31'd0, valid_a}, 32'd0);
      check("rst cg_rate", rate_a, 32'd0);
      check("rst nz_count", {27'd0, nz_a}, 32'd0);
      check("rst sign_hidden", {31'd0, hid_a}, 32'd0);
      check("rst coeff_ready", {31'd0, ready_a}, 32'd1);
      rst = 1'b0;
      coeff_valid = 1'b0;
      @(posedge clk); #1;

      fill(16, 0, 100);
      run_group("zero", 1'b1, 0);
      check("zero literal", rate_a, 32'd1600);

      fill(3, 0, 1000);
      grp_abs[0] = 3;
      grp_abs[2] = 1;
      run_group("short", 1'b1, 0);
      check("short literal", rate_a, 32'd68536);

      fill(16, 0, 0);
      grp_abs[0] = 2;
      grp_abs[5] = 1;
      run_group("sdh", 1'b1, 3);
      check("sdh literal", rate_a, 32'd32768);
      check("nosdh literal", rate_b, 32'd65536);

      fill(2, 0, 32'hFFFF_0000);
      run_group("sat", 1'b1, 0);
      check("sat literal", rate_a, 32'hFFFF_FFFF);

      fill(16, 1, 5);
      run_group("nolast", 1'b0, 0);

      fill(3, 5, 7);
      for (int i = 0; i < 3; i++) begin
         coeff_valid = 1'b1;
         coeff_abs   = 16'd5;
         ctx_rate    = 32'd7;
         @(posedge clk); #1;
      end
      coeff_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst valid", {31'd0, valid_a}, 32'd0);
      check("midrst ready", {31'd0, ready_a}, 32'd1);
      fill(1, 1, 10);
      run_group("midrst", 1'b1, 0);
      check("midrst literal", rate_a, 32'd32778);

      for (int g = 0; g < 40; g++) begin
         grp_len = $urandom_range(1, 16);
         for (int i = 0; i < 16; i++) begin
            grp_abs[i] = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 65535);
            grp_ctx[i] = ($urandom_range(0, 7) == 0) ? $urandom() : $urandom_range(0, 5000);
         end
         if (grp_len == 16 && $urandom_range(0, 1) == 0)
            run_group("rand_nolast", 1'b0, $urandom_range(0, 2));
         else
            run_group("rand", 1'b1, $urandom_range(0, 2));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/cg_rate_accumulator.md
Name: cg_rate_accumulator

Overview:
Downstream consumer of sign_bit_cost in the CABAC rate estimator. Accumulates per-coefficient rate over one 4x4 coefficient group (CG) for RDOQ. Per coefficient, the rate is the context-coded bin cost plus one bypass sign-bin cost (IEP_RATE) for each nonzero level. At group close it applies the HEVC sign-data-hiding (SDH) discount, then emits the CG rate on a valid/ready handshake.

Parameters:
IEP_RATE, 16'h8000, cost of one equiprobable bypass bin (fixed-point 1.15, 32768 = 1 bit); same value fed to sign_bit_cost
SBH_EN, 1, 1 = apply sign-data-hiding discount, 0 = never hide
CG_SIZE, 16, coefficients per group (power of 2, max 16)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
coeff_valid  input  1  upstream coefficient valid
coeff_ready  output  1  block can accept a coefficient
coeff_abs  input  16  absolute level of the coefficient, in scan order
coeff_last  input  1  last coefficient of the group
ctx_rate  input  32  context-coded bin cost for this coefficient
out_valid  output  1  cg_rate/nz_count/sign_hidden valid
out_ready  input  1  downstream accepts the result
cg_rate  output  32  total group rate, saturating
nz_count  output  5  number of nonzero coefficients in the group (0..16)
sign_hidden  output  1  SDH discount applied to this group

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; acc, nz_count, idx, first/last nonzero index cleared. Outputs: out_valid=0, cg_rate=0, nz_count=0, sign_hidden=0, coeff_ready=1. Reset overrides all other inputs in the same cycle, including mid-group and mid-output.
- States: IDLE, ACCUM, FINAL, OUTPUT.
- Coefficient handshake = coeff_valid & coeff_ready. coeff_ready=1 in IDLE and ACCUM, 0 in FINAL and OUTPUT.
- IDLE: on handshake, the accumulator loads that coefficient's cost and idx becomes 1. Next state is ACCUM, or FINAL if that coefficient closes the group.
- ACCUM: on each handshake, acc += ctx_rate + (coeff_abs!=0 ? IEP_RATE : 0), and idx increments. No handshake means hold.
- Nonzero tracking: on the first nonzero coefficient, record first_nz=idx. On every nonzero, record last_nz=idx and nz_count+1.
- Group close: the handshake carries coeff_last=1, or the coefficient is number CG_SIZE (idx==CG_SIZE-1). Next state is FINAL. A missing coeff_last at CG_SIZE does not stall the block.
- FINAL (1 cycle): sign_hidden = SBH_EN & (nz_count>0) & (last_nz - first_nz >= 4). If hidden, cg_rate = acc - IEP_RATE, otherwise cg_rate = acc. out_valid asserts on this edge. The result is visible on the second rising edge after the last-coefficient handshake. Next state is OUTPUT.
- OUTPUT: cg_rate, nz_count, sign_hidden and out_valid are held stable until out_valid & out_ready. On that edge: out_valid=0, internal accumulators cleared, next state IDLE. Output data registers keep their last value after out_valid drops. No coefficient is accepted while in OUTPUT.
- Arithmetic: the 32-bit accumulator saturates at 32'hFFFF_FFFF and never wraps. The SDH subtraction is applied to the saturated value. Because SDH requires at least one nonzero coefficient, acc >= IEP_RATE whenever hidden, so the subtraction cannot underflow.
- Throughput: one coefficient per cycle in ACCUM. Minimum gap between groups is 2 cycles (FINAL + OUTPUT) when out_ready=1.

Test Plan:
- Reset: hold rst=1 for 2 cycles with coeff_valid=1 -> out_valid=0, cg_rate=0, nz_count=0, sign_hidden=0, coeff_ready=1.
- Zero group: 16 coefficients, abs=0, ctx_rate=100, coeff_last only on the 16th, out_ready=1 -> cg_rate=1600, nz_count=0, sign_hidden=0; out_valid high exactly 1 cycle, 2 edges after the last handshake.
- Short group, no hiding: abs={3,0,1}, ctx_rate=1000 each, coeff_last on the 3rd -> cg_rate=3000+2*32768=68536, nz_count=2, sign_hidden=0 (distance 2).
- Sign hiding: SBH_EN=1, abs nonzero at idx 0 and 5, zero elsewhere, ctx_rate=0, 16 coefficients -> cg_rate=32768, nz_count=2, sign_hidden=1. With SBH_EN=0 -> cg_rate=65536, sign_hidden=0.
- Backpressure and saturation:
  - Hold out_ready=0 for 3 cycles while coeff_valid=1 -> outputs stable, coeff_ready=0, no coefficient consumed; next group sums correctly after release.
  - ctx_rate=32'hFFFF_0000 on 2 coefficients -> cg_rate=32'hFFFF_FFFF.
- Reset mid-group: accept 3 nonzero coefficients, pulse rst=1 for 1 cycle, then send a 1-coefficient group (abs=1, ctx_rate=10, coeff_last=1) -> cg_rate=32778, nz_count=1, sign_hidden=0.
